// File: rtl/aes_pkg.sv
// Shared AES constants, the inverse key-schedule state type and the forward S-box.
// Key words are packed big-endian: word0 occupies the most significant 32 bits.
package aes_pkg;

  localparam int AES128_ROUNDS = 10;
  localparam int KEY_W         = 128;
  localparam int WORD_W        = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    FIN  = 2'd2
  } inv_ks_state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX[b];
  endfunction

endpackage

// File: rtl/AES_KeyExpansion_Reverse_calc.sv
// One backward step of the AES-128 key expansion: given the key of round r,
// recovers the key of round r-1. Purely combinational.
module AES_KeyExpansion_Reverse_calc
  import aes_pkg::*;
(
  input  logic [WORD_W-1:0] word_in_0,
  input  logic [WORD_W-1:0] word_in_1,
  input  logic [WORD_W-1:0] word_in_2,
  input  logic [WORD_W-1:0] word_in_3,
  input  logic [3:0]        round_number,
  output logic [WORD_W-1:0] previous_round_word_0,
  output logic [WORD_W-1:0] previous_round_word_1,
  output logic [WORD_W-1:0] previous_round_word_2,
  output logic [WORD_W-1:0] previous_round_word_3
);

  // rcon of the round whose key is being undone; 0 outside 1..10 so no step is implied there.
  function automatic logic [7:0] rcon(input logic [3:0] rnd);
    case (rnd)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [WORD_W-1:0] g_function(input logic [WORD_W-1:0] w,
                                                   input logic [3:0] rnd);
    logic [WORD_W-1:0] rot;
    rot = {w[23:0], w[31:24]};
    return {sbox(rot[31:24]) ^ rcon(rnd), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};
  endfunction

  // Words 1..3 of the older key fall out of neighbouring XORs; word 0 needs g() of the
  // recovered word 3.
  always_comb begin
    previous_round_word_3 = word_in_3 ^ word_in_2;
    previous_round_word_2 = word_in_2 ^ word_in_1;
    previous_round_word_1 = word_in_1 ^ word_in_0;
    previous_round_word_0 = word_in_0 ^ g_function(word_in_3 ^ word_in_2, round_number);
  end

endmodule

// File: rtl/aes_inv_key_schedule_ctrl.sv
// Walks an AES-128 key schedule backwards from the round-10 key, presenting
// round keys 10..0 one per valid/ready handshake, then pulses done.
module aes_inv_key_schedule_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] last_key_in,
  output logic             busy,
  output logic [KEY_W-1:0] key_out,
  output logic [3:0]       key_round,
  output logic             key_valid,
  input  logic             key_ready,
  output logic             done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  inv_ks_state_t    state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [3:0]       round_q, round_d;
  logic [KEY_W-1:0] prev_key;

  AES_KeyExpansion_Reverse_calc u_reverse (
    .word_in_0             (key_q[4*WORD_W-1 -: WORD_W]),
    .word_in_1             (key_q[3*WORD_W-1 -: WORD_W]),
    .word_in_2             (key_q[2*WORD_W-1 -: WORD_W]),
    .word_in_3             (key_q[1*WORD_W-1 -: WORD_W]),
    .round_number          (round_q),
    .previous_round_word_0 (prev_key[4*WORD_W-1 -: WORD_W]),
    .previous_round_word_1 (prev_key[3*WORD_W-1 -: WORD_W]),
    .previous_round_word_2 (prev_key[2*WORD_W-1 -: WORD_W]),
    .previous_round_word_3 (prev_key[1*WORD_W-1 -: WORD_W])
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      round_q <= round_d;
    end
  end

  // Handshake: a key transfers on any cycle with key_valid & key_ready; key_valid never
  // depends on key_ready, and key_out/key_round hold until the transfer happens.
  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    round_d   = round_q;
    busy      = 1'b0;
    key_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          key_d   = last_key_in;
          round_d = LAST_ROUND;
          state_d = EMIT;
        end
      end
      EMIT: begin
        busy      = 1'b1;
        key_valid = 1'b1;
        if (key_ready) begin
          if (round_q != 4'd0) begin
            key_d   = prev_key;
            round_d = round_q - 4'd1;
          end else begin
            state_d = FIN;
          end
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign key_out   = key_q;
  assign key_round = round_q;

endmodule

// File: tb/tb_aes_inv_key_schedule_ctrl.sv
// Bench for the inverse key-schedule walker: a forward-expansion model fills an
// expected queue of {round, key}; a monitor pops it on every accepted key.
module tb_aes_inv_key_schedule_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] last_key_in;
  logic         busy;
  logic [127:0] key_out;
  logic [3:0]   key_round;
  logic         key_valid;
  logic         key_ready;
  logic         done;

  aes_inv_key_schedule_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .last_key_in (last_key_in),
    .busy        (busy),
    .key_out     (key_out),
    .key_round   (key_round),
    .key_valid   (key_valid),
    .key_ready   (key_ready),
    .done        (done)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", 0, 0);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [131:0] exp_q[$];
  int           chk_cnt  = 0;
  int           pass_cnt = 0;
  int           done_cnt = 0;
  int unsigned  done_cyc = 0;
  int unsigned  valid_rise_cyc = 0;
  bit           rdy_rand = 1'b0;
  logic [7:0]   sb[256];

  task automatic check(input string name, input logic [135:0] act, input logic [135:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // ---------------- reference model: GF(2^8) S-box + forward expansion ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic       hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return 8'((v << n) | (v >> (8 - n)));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  // Expand k0 forwards to 44 words, queue keys 10..0 and return the round-10 key.
  task automatic push_walk(input logic [127:0] k0, output logic [127:0] k10);
    logic [31:0] w[44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 10; r >= 0; r--)
      exp_q.push_back({4'(r), w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]});
    k10 = {w[40], w[41], w[42], w[43]};
  endtask

  function automatic logic [127:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    key_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // ---------------- monitor ----------------
  bit           stall_prev = 1'b0;
  logic [131:0] stall_val;
  bit           prev_valid = 1'b0;

  always @(negedge clk) begin
    if (stall_prev && key_valid) check("stall_hold", {key_round, key_out}, stall_val);
    stall_prev = key_valid && !key_ready && !rst;
    stall_val  = {key_round, key_out};
    if (key_valid && key_ready && !rst) begin
      if (exp_q.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_key: got round %0d key %h, expected no key", key_round, key_out);
      end else begin
        check("key", {key_round, key_out}, exp_q.pop_front());
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (key_valid && !prev_valid) valid_rise_cyc = cyc;
    prev_valid = key_valid;
  end

  // ---------------- driver tasks ----------------
  int unsigned start_cyc;

  task automatic start_walk(input logic [127:0] k);
    @(posedge clk); #1;
    start       = 1'b1;
    last_key_in = k;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n0 = done_cnt;
    int i;
    for (i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != n0) break;
    end
    if (i == budget) begin
      chk_cnt++;
      $display("FAIL %s: got no done within %0d cycles, expected a done pulse", name, budget);
    end
  endtask

  task automatic wait_round(input string name, input logic [3:0] r);
    int i;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (key_valid && key_round == r) break;
    end
    if (i == 100) begin
      chk_cnt++;
      $display("FAIL %s: got no round %0d within 100 cycles, expected it", name, r);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [127:0] k10, k10b;
    int           n_done;

    rst = 1'b1; start = 1'b0; last_key_in = '0; key_ready = 1'b1;
    build_sbox();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {busy, key_valid, done, key_round, key_out}, 136'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // FIPS-197 A.1 walk with ready held high.
    rdy_rand = 1'b0;
    push_walk(128'h2b7e151628aed2a6abf7158809cf4f3c, k10);
    exp_q[0]  = {4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    exp_q[1]  = {4'd9,  128'hac7766f319fadc2128d12941575c006e};
    exp_q[10] = {4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
    start_walk(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    wait_done("fips_done", 100);
    check("fips_done_latency", 136'(done_cyc - start_cyc), 136'd12);
    check("fips_drained", 136'(exp_q.size()), 136'd0);

    // Random backpressure.
    rdy_rand = 1'b1;
    push_walk(rand_key(), k10);
    start_walk(k10);
    wait_done("bp_done", 300);
    check("bp_drained", 136'(exp_q.size()), 136'd0);

    // start in mid-walk is ignored.
    rdy_rand = 1'b0;
    push_walk(rand_key(), k10);
    start_walk(k10);
    wait_round("mid_start_round", 4'd5);
    @(posedge clk); #1;
    start = 1'b1; last_key_in = rand_key();
    repeat (2) @(posedge clk); #1;
    start = 1'b0;
    wait_done("mid_start_done", 100);
    check("mid_start_drained", 136'(exp_q.size()), 136'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_start_no_rewalk", 136'(key_valid), 136'd0);

    // Reset at round 3 aborts silently; start during reset is ignored.
    push_walk(rand_key(), k10);
    start_walk(k10);
    wait_round("rst_round", 4'd3);
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b1; last_key_in = rand_key();
    exp_q.delete();
    n_done = done_cnt;
    @(posedge clk);
    @(negedge clk);
    check("mid_reset_outputs", {busy, key_valid, done, key_round, key_out}, 136'h0);
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    repeat (15) @(posedge clk);
    @(negedge clk);
    check("mid_reset_no_done", 136'(done_cnt), 136'(n_done));
    check("start_with_rst_ignored", 136'(key_valid), 136'd0);
    push_walk(rand_key(), k10);
    start_walk(k10);
    wait_done("post_reset_done", 100);
    check("post_reset_drained", 136'(exp_q.size()), 136'd0);

    // Back-to-back walks with start held high.
    push_walk(rand_key(), k10);
    push_walk(rand_key(), k10b);
    @(posedge clk); #1;
    start = 1'b1; last_key_in = k10;
    repeat (3) @(posedge clk); #1;
    last_key_in = k10b;
    wait_done("b2b_first_done", 100);
    n_done = int'(done_cyc);
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("b2b_second_done", 100);
    check("b2b_gap", 136'(valid_rise_cyc - n_done), 136'd2);
    check("b2b_drained", 136'(exp_q.size()), 136'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("b2b_no_third", 136'(key_valid), 136'd0);

    // Cross-check: random round-0 keys under random backpressure.
    rdy_rand = 1'b1;
    for (int n = 0; n < 50; n++) begin
      push_walk(rand_key(), k10);
      start_walk(k10);
      wait_done("xchk_done", 300);
    end
    check("xchk_drained", 136'(exp_q.size()), 136'd0);

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
